// File: rtl/usart_fifo.sv
// usart_fifo - parametrised synchronous FIFO for the USART TX/RX data paths.
//
// Single clock (CPU_Clk), asynchronous active-low reset (Reset_n).
// Depth is 2^ADDR_W and every entry is usable. The pointers carry one extra
// wrap bit, so full and empty are told apart without a separate counter.
// data_out is first-word-fall-through and reads as 0 while the FIFO is empty.
//
// Ports:
//   CPU_Clk       in   clock, rising edge
//   Reset_n       in   asynchronous active-low reset
//   Clear         in   synchronous flush, wins over WR/RD
//   data_in       in   write data [DATA_W]
//   WR            in   write request
//   RD            in   read request (pops head word)
//   data_out      out  head word, 0 when empty [DATA_W]
//   full          out  level == 2^ADDR_W
//   empty         out  level == 0
//   almost_full   out  level >= AF_LVL
//   almost_empty  out  level <= AE_LVL
//   level         out  stored word count [ADDR_W+1]
//   overflow      out  sticky rejected-write flag
//   underflow     out  sticky rejected-read flag
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   defined   -> overflow/underflow are sticky registers cleared by Clear/reset
//   undefined -> overflow/underflow are tied to 0, no flag registers exist
module usart_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 4
) (
  input  logic              CPU_Clk,
  input  logic              Reset_n,
  input  logic              Clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              WR,
  input  logic              RD,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_THR = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_THR = AE_LVL[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              wr_en;
  logic              rd_en;

  // Flags come straight from the registered pointers so none of them lags.
  assign level        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign almost_full  = (level >= AF_THR);
  assign almost_empty = (level <= AE_THR);

  // A write into a full FIFO is only legal if the head leaves in the same cycle.
  assign rd_en = RD && !Clear && !empty;
  assign wr_en = WR && !Clear && (!full || RD);

  always_ff @(posedge CPU_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  // Reset_n gates the write so nothing lands while reset is held.
  always_ff @(posedge CPU_Clk) begin
    if (wr_en && Reset_n) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
  end

  assign data_out = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge CPU_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (Clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (WR && full && !RD) ovf_q <= 1'b1;
      if (RD && empty)       unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_usart_fifo.sv
module tb_usart_fifo;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       CPU_Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Clear   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       WR      = 1'b0;
  logic       RD      = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] level;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  usart_fifo #(.DATA_W(8), .ADDR_W(4), .AF_LVL(12), .AE_LVL(4)) dut (
    .CPU_Clk(CPU_Clk), .Reset_n(Reset_n), .Clear(Clear), .data_in(data_in),
    .WR(WR), .RD(RD), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CPU_Clk = ~CPU_Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge CPU_Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #23;
    checks++; if (level !== 5'd0)      begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b expected 0", almost_full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae: got %b expected 1", almost_empty); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b%b expected 00", overflow, underflow); end
    checks++; if (data_out !== 8'h00)  begin errors++; $display("FAIL rst_dout: got 0x%0h expected 0x00", data_out); end
    @(negedge CPU_Clk);
    Reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      WR = 1'b1; data_in = 8'(i);
      cycle();
      checks++; if (level !== 5'(i)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level, i); end
      checks++; if (almost_full !== (i >= 12)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, i >= 12); end
      checks++; if (almost_empty !== (i <= 4)) begin errors++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, almost_empty, i <= 4); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, i == 16); end
      checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL fill_dout[%0d]: got 0x%0h expected 0x01", i, data_out); end
    end
    WR = 1'b0;
  endtask

  task automatic test_overflow();
    WR = 1'b1; RD = 1'b0; data_in = 8'hAA;
    cycle();
    WR = 1'b0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL ovf_dout: got 0x%0h expected 0x01", data_out); end
    checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag: got %b expected %b", overflow, ERR_EN); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ovf_unf: got %b expected 0", underflow); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    WR = 1'b1; RD = 1'b1; data_in = 8'hBB;
    cycle();
    WR = 1'b0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL frw_level: got %0d expected 16", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL frw_full: got %b expected 1", full); end
    checks++; if (data_out !== 8'h02) begin errors++; $display("FAIL frw_dout: got 0x%0h expected 0x02", data_out); end
    for (int k = 1; k <= 15; k++) begin
      cycle();
      exp = (k == 15) ? 8'hBB : 8'(k + 2);
      checks++; if (data_out !== exp) begin errors++; $display("FAIL frw_pop[%0d]: got 0x%0h expected 0x%0h", k, data_out, exp); end
      checks++; if (level !== 5'(16 - k)) begin errors++; $display("FAIL frw_plevel[%0d]: got %0d expected %0d", k, level, 16 - k); end
    end
    cycle();
    RD = 1'b0;
    checks++; if (empty !== 1'b1 || data_out !== 8'h00) begin errors++; $display("FAIL frw_drain: got empty=%b dout=0x%0h expected empty=1 dout=0x00", empty, data_out); end
    checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL frw_ovf_sticky: got %b expected %b", overflow, ERR_EN); end
  endtask

  task automatic test_empty_rw();
    // Reset the sticky flags first so this scenario starts from a clean state.
    Clear = 1'b1;
    cycle();
    Clear = 1'b0;
    WR = 1'b1; RD = 1'b1; data_in = 8'h5A;
    cycle();
    WR = 1'b0;
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL erw_level: got %0d expected 1", level); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL erw_dout: got 0x%0h expected 0x5a", data_out); end
    // The read half was rejected against an empty FIFO.
    checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL erw_unf: got %b expected %b", underflow, ERR_EN); end
    cycle();
    RD = 1'b0;
    checks++; if (empty !== 1'b1 || level !== 5'd0 || data_out !== 8'h00) begin errors++; $display("FAIL erw_pop: got empty=%b level=%0d dout=0x%0h expected 1/0/0x00", empty, level, data_out); end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    bit wr_ok, rd_ok;
    for (int i = 0; i < 40; i++) begin
      WR = (i % 3) != 2;
      RD = (i % 2) == 1;
      data_in = 8'(8'h30 + i);
      rd_ok = RD && (q.size() > 0);
      wr_ok = WR && ((q.size() < 16) || rd_ok);
      cycle();
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(data_in);
      exp_d = (q.size() > 0) ? q[0] : 8'h00;
      checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL wrap_level[%0d]: got %0d expected %0d", i, level, q.size()); end
      checks++; if (data_out !== exp_d) begin errors++; $display("FAIL wrap_dout[%0d]: got 0x%0h expected 0x%0h", i, data_out, exp_d); end
    end
    WR = 1'b0; RD = 1'b1;
    while (q.size() > 0) begin
      cycle();
      void'(q.pop_front());
      exp_d = (q.size() > 0) ? q[0] : 8'h00;
      checks++; if (data_out !== exp_d) begin errors++; $display("FAIL wrap_drain: got 0x%0h expected 0x%0h", data_out, exp_d); end
    end
    RD = 1'b0;
  endtask

  task automatic test_clear();
    RD = 1'b1;
    cycle();
    RD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      WR = 1'b1; data_in = 8'(8'hC0 + i);
      cycle();
    end
    chk("clr_pre_level", 32'(level), 32'd8);
    chk("clr_pre_unf", 32'(underflow), 32'(ERR_EN));
    Clear = 1'b1; WR = 1'b1; data_in = 8'hEE;
    cycle();
    Clear = 1'b0; WR = 1'b0;
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL clr_state: got level=%0d empty=%b expected 0/1", level, empty); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL clr_dout: got 0x%0h expected 0x00", data_out); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL clr_err: got %b%b expected 00", overflow, underflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      WR = 1'b1; data_in = 8'(8'h90 + i);
      cycle();
      if (i == 3) break;
    end
    chk("rmid_pre_level", 32'(level), 32'd4);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rmid_async: got level=%0d empty=%b full=%b expected 0/1/0", level, empty, full); end
    checks++; if (data_out !== 8'h00 || almost_empty !== 1'b1) begin errors++; $display("FAIL rmid_dout: got dout=0x%0h ae=%b expected 0x00/1", data_out, almost_empty); end
    cycle();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rmid_held: got %0d expected 0", level); end
    Reset_n = 1'b1;
    data_in = 8'h77;
    cycle();
    WR = 1'b0;
    checks++; if (level !== 5'd1 || data_out !== 8'h77) begin errors++; $display("FAIL rmid_first: got level=%0d dout=0x%0h expected 1/0x77", level, data_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
